// File: rtl/hamming_secded_decoder.sv
// Pipelined extended-Hamming SECDED decoder with a valid/ready stream on both sides.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   input handshake for code_in and correct_en
//   code_in [N-1:0]     bit k-1 = Hamming position k (1..N-1); bit N-1 = overall even parity
//   correct_en          1 = flip the located bit; 0 = report only
//   out_valid/out_ready output handshake
//   data_out            decoded data; bit 0 = lowest non-power-of-two position
//   syndrome_out        Hamming syndrome of the delivered word
//   err_pos             located position (0 = parity bit or no error)
//   err_single          single error (corrected when correct_en was set)
//   err_double          uncorrectable error
//   cnt_clr             synchronous clear of both counters; wins over an increment
//   cnt_corrected       saturating count of delivered err_single results
//   cnt_uncorrectable   saturating count of delivered err_double results
//
// Stage 1 registers the raw data bits, the syndrome and the overall parity mismatch.
// Stage 2 registers the classified, optionally corrected result and drives the outputs.
module hamming_secded_decoder #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  // Smallest r with 2^r >= DATA_W + r + 1.
  localparam int PAR_W  = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
  localparam int N      = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      code_in,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [PAR_W-1:0]  syndrome_out,
  output logic [PAR_W-1:0]  err_pos,
  output logic              err_single,
  output logic              err_double,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_uncorrectable
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ce;
    logic [PAR_W-1:0]  syn;
    logic              par;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  syn;
    logic [PAR_W-1:0]  pos;
    logic              single;
    logic              dbl;
  } res_t;

  localparam logic [PAR_W:0]   POS_MAX = (PAR_W+1)'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Hamming position carrying data bit i (i-th non-power-of-two position).
  function automatic int data_pos(int i);
    int cnt;
    cnt = 0;
    data_pos = 0;
    for (int k = 1; k < N; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (cnt == i) data_pos = k;
        cnt++;
      end
    end
  endfunction

  logic [2:1]        vld_pipe;
  s1_t               s1;
  res_t              r2, res_c;
  logic              s2_load;
  logic [PAR_W-1:0]  syn_c;
  logic              par_c;
  logic [DATA_W-1:0] raw_data, corr_data;
  logic              s_nz, in_range, flip_en;

  assign s2_load  = !vld_pipe[2] || out_ready;
  assign in_ready = !vld_pipe[1] || s2_load;

  // Syndrome bit j: parity over all positions whose index has bit j set.
  always_comb begin
    syn_c = '0;
    for (int j = 0; j < PAR_W; j++)
      for (int k = 1; k < N; k++)
        if (((k >> j) & 1) == 1) syn_c[j] = syn_c[j] ^ code_in[k-1];
  end

  assign par_c = ^code_in;

  // Parity positions never reach data_out, so only data bits are carried forward;
  // correction then reduces to a per-bit compare against the syndrome.
  assign s_nz     = |s1.syn;
  assign in_range = {1'b0, s1.syn} <= POS_MAX;
  assign flip_en  = s1.ce & s1.par & s_nz & in_range;

  for (genvar i = 0; i < DATA_W; i++) begin : g_data
    assign raw_data[i]  = code_in[data_pos(i)-1];
    assign corr_data[i] = s1.data[i] ^ (flip_en && (s1.syn == PAR_W'(data_pos(i))));
  end

  always_comb begin
    res_c        = '0;
    res_c.data   = corr_data;
    res_c.syn    = s1.syn;
    res_c.single = s1.par & (~s_nz | in_range);
    // Even parity with a nonzero syndrome, or a syndrome pointing past the word.
    res_c.dbl    = s_nz & (~s1.par | ~in_range);
    res_c.pos    = (s1.par & s_nz & in_range) ? s1.syn : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      r2       <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (in_valid && in_ready) s1 <= '{data: raw_data, ce: correct_en, syn: syn_c, par: par_c};
      if (s2_load) vld_pipe[2] <= vld_pipe[1];
      if (s2_load && vld_pipe[1]) r2 <= res_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (cnt_clr) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (vld_pipe[2] && out_ready) begin
      if (r2.single && cnt_corrected != CNT_MAX)
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (r2.dbl && cnt_uncorrectable != CNT_MAX)
        cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
    end
  end

  assign out_valid    = vld_pipe[2];
  assign data_out     = r2.data;
  assign syndrome_out = r2.syn;
  assign err_pos      = r2.pos;
  assign err_single   = r2.single;
  assign err_double   = r2.dbl;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (DATA_W=4, CNT_W=2).
module tb_hamming_secded_decoder;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int PAR_W  = 3;
  localparam int N      = 8;

  logic              clk, rst_n, in_valid, in_ready, correct_en, out_valid, out_ready, cnt_clr;
  logic [N-1:0]      code_in;
  logic [DATA_W-1:0] data_out;
  logic [PAR_W-1:0]  syndrome_out, err_pos;
  logic              err_single, err_double;
  logic [CNT_W-1:0]  cnt_corrected, cnt_uncorrectable;

  int n_cmp = 0;
  int n_bad = 0;

  hamming_secded_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .correct_en(correct_en), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .syndrome_out(syndrome_out), .err_pos(err_pos), .err_single(err_single),
    .err_double(err_double), .cnt_clr(cnt_clr), .cnt_corrected(cnt_corrected),
    .cnt_uncorrectable(cnt_uncorrectable));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  syn;
    logic [PAR_W-1:0]  pos;
    logic              single;
    logic              dbl;
  } res_t;

  // Reference: syndrome = XOR of the indices of all set positions; overall parity by popcount.
  function automatic res_t model(logic [N-1:0] c, logic ce);
    res_t r;
    int s, ones, di;
    logic [N-1:0] fc;
    s = 0; ones = 0;
    for (int k = 1; k < N; k++) if (c[k-1]) s = s ^ k;
    for (int k = 0; k < N; k++) ones += int'(c[k]);
    r.single = 0; r.dbl = 0; r.pos = 0;
    if (ones % 2 == 1) begin
      if (s == 0) r.single = 1;
      else if (s <= N - 1) begin r.single = 1; r.pos = s[PAR_W-1:0]; end
      else r.dbl = 1;
    end else if (s != 0) r.dbl = 1;
    fc = c;
    if (r.single && s != 0 && ce) fc[s-1] = ~fc[s-1];
    r.data = '0; di = 0;
    for (int k = 1; k < N; k++)
      if (k != 1 && k != 2 && k != 4) begin r.data[di] = fc[k-1]; di++; end
    r.syn = s[PAR_W-1:0];
    return r;
  endfunction

  function automatic logic [N-1:0] encode(logic [DATA_W-1:0] d);
    logic [N-1:0] c;
    int di, x;
    c = '0; di = 0; x = 0;
    for (int k = 1; k < N; k++)
      if (k != 1 && k != 2 && k != 4) begin c[k-1] = d[di]; di++; end
    for (int k = 1; k < N; k++) if (c[k-1]) x = x ^ k;
    for (int j = 0; j < PAR_W; j++) if (((x >> j) & 1) == 1) c[(1 << j) - 1] = 1'b1;
    c[N-1] = ^c[N-2:0];
    return c;
  endfunction

  // Drive one word into an empty pipeline; return edges until out_valid (bounded).
  task automatic push_wait(input logic [N-1:0] c, input logic ce, output int lat);
    in_valid = 1; code_in = c; correct_en = ce; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; lat = 1;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; code_in = '0; correct_en = 1; out_ready = 1; cnt_clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if ({data_out, syndrome_out, err_pos, err_single, err_double} !== 12'h000) begin
      n_bad++; $display("FAIL reset_result: got %h want 000", {data_out, syndrome_out, err_pos, err_single, err_double}); end
    n_cmp++; if ({cnt_corrected, cnt_uncorrectable} !== 4'h0) begin
      n_bad++; $display("FAIL reset_counters: got %h want 0", {cnt_corrected, cnt_uncorrectable}); end
  endtask

  task automatic test_clean();
    int lat;
    push_wait(8'h66, 1'b1, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL clean_latency: got %0d want 2", lat); end
    n_cmp++; if ({data_out, syndrome_out, err_pos, err_single, err_double} !== {4'b1101, 3'd0, 3'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL clean_result: got %h want %h", {data_out, syndrome_out, err_pos, err_single, err_double}, {4'b1101, 8'h00}); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clean_no_dup: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_single();
    int lat;
    push_wait(8'h76, 1'b1, lat);
    n_cmp++; if ({data_out, syndrome_out, err_pos, err_single, err_double} !== {4'b1101, 3'd5, 3'd5, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL single_fix: got %h want %h", {data_out, syndrome_out, err_pos, err_single, err_double}, {4'b1101, 3'd5, 3'd5, 2'b10}); end
    @(posedge clk); #1;
    n_cmp++; if (cnt_corrected !== 2'd1) begin n_bad++; $display("FAIL single_cnt1: got %0d want 1", cnt_corrected); end
    push_wait(8'h76, 1'b0, lat);
    n_cmp++; if ({data_out, syndrome_out, err_pos, err_single, err_double} !== {4'b1111, 3'd5, 3'd5, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL single_detect_only: got %h want %h", {data_out, syndrome_out, err_pos, err_single, err_double}, {4'b1111, 3'd5, 3'd5, 2'b10}); end
    @(posedge clk); #1;
    n_cmp++; if (cnt_corrected !== 2'd2) begin n_bad++; $display("FAIL single_cnt2: got %0d want 2", cnt_corrected); end
  endtask

  task automatic test_double_and_parity();
    int lat;
    push_wait(8'h77, 1'b1, lat);
    n_cmp++; if ({data_out, syndrome_out, err_pos, err_single, err_double} !== {4'b1111, 3'd4, 3'd0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL double_result: got %h want %h", {data_out, syndrome_out, err_pos, err_single, err_double}, {4'b1111, 3'd4, 3'd0, 2'b01}); end
    @(posedge clk); #1;
    n_cmp++; if (cnt_uncorrectable !== 2'd1) begin n_bad++; $display("FAIL double_cnt: got %0d want 1", cnt_uncorrectable); end
    push_wait(8'hE6, 1'b1, lat);
    n_cmp++; if ({data_out, syndrome_out, err_pos, err_single, err_double} !== {4'b1101, 3'd0, 3'd0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL parity_bit_err: got %h want %h", {data_out, syndrome_out, err_pos, err_single, err_double}, {4'b1101, 3'd0, 3'd0, 2'b10}); end
    @(posedge clk); #1;
    n_cmp++; if (cnt_corrected !== 2'd3) begin n_bad++; $display("FAIL parity_cnt: got %0d want 3", cnt_corrected); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] w[3];
    int idx;
    for (int i = 0; i < 3; i++) w[i] = encode(DATA_W'(i + 1));
    idx = 0; out_ready = 0; correct_en = 1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (idx < 3); if (idx < 3) code_in = w[idx];
      #3;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = (idx < 3); if (idx < 3) code_in = w[idx];
    #3;
    n_cmp++; if (idx != 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1;
    for (int j = 0; j < 3; j++) begin
      in_valid = (idx < 3); if (idx < 3) code_in = w[idx];
      #3;
      n_cmp++; if (!(out_valid === 1'b1 && data_out === DATA_W'(j + 1))) begin
        n_bad++; $display("FAIL bp_order_%0d: got valid %b data %h want valid 1 data %h", j, out_valid, data_out, j + 1); end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_saturate();
    int lat;
    cnt_clr = 1; @(posedge clk); #1; cnt_clr = 0;
    n_cmp++; if ({cnt_corrected, cnt_uncorrectable} !== 4'h0) begin
      n_bad++; $display("FAIL sat_clear: got %h want 0", {cnt_corrected, cnt_uncorrectable}); end
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] c;
      c = encode(DATA_W'($urandom));
      c[$urandom_range(0, N - 1)] ^= 1'b1;
      push_wait(c, 1'b1, lat);
      @(posedge clk); #1;
    end
    n_cmp++; if (cnt_corrected !== 2'd3) begin n_bad++; $display("FAIL sat_value: got %0d want 3", cnt_corrected); end
    push_wait(8'h76, 1'b1, lat);
    cnt_clr = 1; @(posedge clk); #1; cnt_clr = 0;
    n_cmp++; if (cnt_corrected !== 2'd0) begin n_bad++; $display("FAIL clr_priority_sat: got %0d want 0", cnt_corrected); end
    push_wait(8'h76, 1'b1, lat); @(posedge clk); #1;
    push_wait(8'h76, 1'b1, lat);
    cnt_clr = 1; @(posedge clk); #1; cnt_clr = 0;
    n_cmp++; if (cnt_corrected !== 2'd0) begin n_bad++; $display("FAIL clr_priority_inc: got %0d want 0", cnt_corrected); end
  endtask

  task automatic test_reset_midstream();
    int lat;
    res_t e;
    push_wait(8'h76, 1'b1, lat); @(posedge clk); #1;
    out_ready = 1; correct_en = 1;
    in_valid = 1; code_in = encode(4'h9); @(posedge clk); #1;
    code_in = encode(4'h6); @(posedge clk); #1;
    in_valid = 0;
    #2 rst_n = 0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    n_cmp++; if ({cnt_corrected, cnt_uncorrectable} !== 4'h0) begin
      n_bad++; $display("FAIL rst_mid_counters: got %h want 0", {cnt_corrected, cnt_uncorrectable}); end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    push_wait(encode(4'hA) ^ 8'h04, 1'b1, lat);
    e = model(encode(4'hA) ^ 8'h04, 1'b1);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL rst_mid_latency: got %0d want 2", lat); end
    n_cmp++; if ({data_out, syndrome_out, err_pos, err_single, err_double} !== {e.data, e.syn, e.pos, e.single, e.dbl}) begin
      n_bad++; $display("FAIL rst_mid_result: got %h want %h", {data_out, syndrome_out, err_pos, err_single, err_double}, {e.data, e.syn, e.pos, e.single, e.dbl}); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flushed: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e;
    logic pend, stall;
    logic [N-1:0] pc;
    logic pce;
    logic [11:0] held;
    int mc, mu, drain;
    pend = 0; stall = 0; held = '0; mc = 0; mu = 0; pc = '0; pce = 0;
    cnt_clr = 1; @(posedge clk); #1; cnt_clr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        int n1, n2, ne;
        pc = encode(DATA_W'($urandom));
        ne = $urandom_range(0, 2);
        n1 = $urandom_range(0, N - 1);
        n2 = (n1 + $urandom_range(1, N - 1)) % N;
        if (ne >= 1) pc[n1] ^= 1'b1;
        if (ne == 2) pc[n2] ^= 1'b1;
        pce = 1'($urandom_range(0, 1));
        pend = 1;
      end
      in_valid = pend; code_in = pc; correct_en = pce;
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      #3;
      n_cmp++; if ({cnt_corrected, cnt_uncorrectable} !== {2'(mc), 2'(mu)}) begin
        n_bad++; $display("FAIL rnd_counters cyc %0d: got %h want %h", cyc, {cnt_corrected, cnt_uncorrectable}, {2'(mc), 2'(mu)}); end
      if (stall) begin
        n_cmp++; if (!(out_valid === 1'b1 && {data_out, syndrome_out, err_pos, err_single, err_double} === held)) begin
          n_bad++; $display("FAIL rnd_stall_hold cyc %0d: got %b/%h want 1/%h", cyc, out_valid, {data_out, syndrome_out, err_pos, err_single, err_double}, held); end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_bad++; $display("FAIL rnd_spurious cyc %0d: got output with empty scoreboard", cyc); end
        else begin
          e = q.pop_front();
          if ({data_out, syndrome_out, err_pos, err_single, err_double} !== {e.data, e.syn, e.pos, e.single, e.dbl}) begin
            n_bad++; $display("FAIL rnd_result cyc %0d: got %h want %h", cyc, {data_out, syndrome_out, err_pos, err_single, err_double}, {e.data, e.syn, e.pos, e.single, e.dbl}); end
          if (!cnt_clr) begin
            if (e.single && mc < 3) mc++;
            if (e.dbl && mu < 3) mu++;
          end
        end
      end
      if (cnt_clr) begin mc = 0; mu = 0; end
      stall = out_valid && !out_ready;
      held = {data_out, syndrome_out, err_pos, err_single, err_double};
      if (in_valid && in_ready) begin q.push_back(model(pc, pce)); pend = 0; end
      @(posedge clk); #1;
    end
    in_valid = 0; cnt_clr = 0; out_ready = 1; drain = 0;
    while (q.size() != 0 && drain < 20) begin
      #3;
      if (out_valid) begin
        e = q.pop_front();
        n_cmp++; if ({data_out, syndrome_out, err_pos, err_single, err_double} !== {e.data, e.syn, e.pos, e.single, e.dbl}) begin
          n_bad++; $display("FAIL rnd_drain: got %h want %h", {data_out, syndrome_out, err_pos, err_single, err_double}, {e.data, e.syn, e.pos, e.single, e.dbl}); end
      end
      @(posedge clk); #1; drain++;
    end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd_lost: got %0d words outstanding want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double_and_parity();
    test_backpressure();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
Pipelined, parametrised Hamming SECDED decoder: the successor to the fixed (7,4) switch-driven corrector. Accepts an extended Hamming codeword (Hamming positions plus overall parity) over a valid/ready stream and produces the data word after single-error correction, with syndrome, error classification and saturating error counters. Sits between the receive path and the LED/7-segment display logic, which consumes data_out and syndrome_out.

Parameters:
DATA_W, 4, data bits per word (>=1)
CNT_W, 16, width of each error counter
PAR_W, derived localparam, smallest r with 2^r >= DATA_W + r + 1 (3 for DATA_W=4)
N, derived localparam, codeword width = DATA_W + PAR_W + 1 (8 for DATA_W=4)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  code_in valid
in_ready  out  1  decoder can accept code_in this cycle
code_in  in  N  codeword; bit[k-1] = Hamming position k (k=1..N-1); bit[N-1] = overall even parity
correct_en  in  1  1 = correct single errors; 0 = detect only; sampled with code_in
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
data_out  out  DATA_W  decoded data; bit0 = lowest non-power-of-two position
syndrome_out  out  PAR_W  Hamming syndrome (bit j = parity check over positions with bit j set)
err_pos  out  PAR_W  corrected position (0 = overall parity bit or no error)
err_single  out  1  single error detected (corrected if correct_en)
err_double  out  1  uncorrectable error detected
cnt_clr  in  1  synchronous clear of both counters
cnt_corrected  out  CNT_W  saturating count of delivered err_single results
cnt_uncorrectable  out  CNT_W  saturating count of delivered err_double results

Behaviour:
- Reset (async, rst_n=0): both stage valids, out_valid, all result outputs, both counters -> 0. In-flight words discarded. in_ready = 1 after reset.
- Two register stages: S1 captures code_in, correct_en, syndrome s, overall parity mismatch p. S2 holds corrected data and flags; S2 drives outputs.
- Latency: 2 cycles from in handshake to out_valid with no backpressure; throughput 1 word/cycle.
- Handshake: S2 loads when !out_valid || out_ready. S1 advances when S2 loads. in_ready = !s1_valid || S2 loads (combinational from out_ready). Outputs stable while out_valid && !out_ready. Transfer only on valid && ready. Strict in-order delivery, no drops, no duplicates.
- Classification (s, p):
  - s=0, p=0: no error; flags 0, err_pos 0.
  - s=0, p=1: error in parity bit; err_single=1, err_pos=0, data unchanged.
  - s!=0, p=1, s<=N-1: err_single=1, err_pos=s; flip position s if correct_en.
  - s!=0, p=1, s>N-1: invalid position -> err_double=1, no flip.
  - s!=0, p=0: err_double=1, err_pos=0, data extracted uncorrected.
- err_single and err_double are never both 1. With correct_en=0, flags and err_pos are reported identically but no bit is flipped.
- Counters: increment on out_valid && out_ready when the delivered flag is set; saturate at 2^CNT_W-1. cnt_clr has priority: counter -> 0, same-cycle increment dropped.
- Reset asserted mid-stream: pipeline flushed. First word after release is accepted on the first cycle with in_valid=1.

Test Plan:
- DATA_W=4, code_in=8'h66 (data 1101, clean) -> 2 cycles later data_out=4'b1101, syndrome_out=3'b000, flags 0.
- code_in=8'h76 (pos5 flipped) -> data_out=4'b1101, syndrome_out=3'b101, err_pos=5, err_single=1, cnt_corrected=1. Repeat with correct_en=0 -> data_out=4'b1111, same flags.
- code_in=8'h77 (pos5+pos1) -> syndrome_out=3'b100, err_double=1, data_out=4'b1111, cnt_uncorrectable=1. code_in=8'hE6 -> err_single=1, err_pos=0, data_out=4'b1101.
- Backpressure: hold out_ready=0, push 3 words -> in_ready=0 after 2 accepted. Release out_ready -> 3 results delivered in order on consecutive cycles.
- CNT_W=2: deliver 5 single-error words -> cnt_corrected=3 (saturated). cnt_clr asserted together with a delivered error -> counter 0.
- rst_n pulsed low with 2 words in flight -> out_valid=0 and counters=0 immediately. After release, a new word returns correctly in 2 cycles.
